// File: rtl/gate_mode_pkg.sv
// Shared encodings and helpers for the Hack board two-button gate tester.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package gate_mode_pkg;

   // Gate selected by MODE; the encoding is visible on the MODE port.
   localparam logic [1:0] MODE_AND  = 2'd0;
   localparam logic [1:0] MODE_OR   = 2'd1;
   localparam logic [1:0] MODE_XOR  = 2'd2;
   localparam logic [1:0] MODE_NAND = 2'd3;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_ARM    = 2'd1,
      ST_SELECT = 2'd2
   } state_e;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Evaluate the selected gate on the two debounced button levels.
   function automatic logic gate_eval(input logic [1:0] mode, input logic a, input logic b);
      logic r;
      case (mode)
         MODE_AND:  r = a & b;
         MODE_OR:   r = a | b;
         MODE_XOR:  r = a ^ b;
         default:   r = ~(a & b);
      endcase
      return r;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// One button: invert, 2-flop synchronise, debounce, and flag each press.
// Latency: raw edge -> level change = 2 + DEBOUNCE_CYCLES cycles; press pulses with the level rise.
// Backpressure: none; the raw pin is sampled every cycle.
module button_debounce
   import gate_mode_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic but_n,
   output logic level,
   output logic press
);

   localparam int            CW       = cnt_w(int'(DEBOUNCE_CYCLES));
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 16'd1);

   logic [1:0]    sync_q, sync_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Synchronise the pressed level and run the stability counter against it.
   always_comb begin
      sync_d  = {sync_q[0], ~but_n};
      level_d = level_q;
      cnt_d   = cnt_q;
      if (sync_q[1] == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         level_d = sync_q[1];
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
      // Only the released->pressed transition is an event.
      press_d = level_d & ~level_q;
   end

   // Input path state; everything clears to "released".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/gate_mode_ctrl.sv
// Two-button gate tester: debounced buttons drive a selectable gate onto the LEDs; long hold enters mode select.
// Latency: debounced level change -> LED 1 cycle; raw pin -> LED 3 + DEBOUNCE_CYCLES cycles.
// Backpressure: none. Define GATE_MODE_TIMEOUT_EN to auto-leave SELECT after TIMEOUT_CYCLES idle cycles.
module gate_mode_ctrl
   import gate_mode_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [23:0] HOLD_CYCLES     = 24'd6000000,
   parameter logic [23:0] BLINK_CYCLES    = 24'd3000000,
   parameter logic [27:0] TIMEOUT_CYCLES  = 28'd60000000
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [1:0] BUT,
   output logic [1:0] LED,
   output logic [1:0] MODE
);

   localparam int            HW         = cnt_w(int'(HOLD_CYCLES));
   localparam int            BW         = cnt_w(int'(BLINK_CYCLES));
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 24'd1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 24'd1);

   logic [1:0] p_lvl;
   logic [1:0] p_press;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb0 (
      .clk   (CLK),
      .rst_n (RST_N),
      .but_n (BUT[0]),
      .level (p_lvl[0]),
      .press (p_press[0])
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
      .clk   (CLK),
      .rst_n (RST_N),
      .but_n (BUT[1]),
      .level (p_lvl[1]),
      .press (p_press[1])
   );

   state_e        state_q, state_d;
   logic [1:0]    mode_q, mode_d;
   logic [1:0]    led_q, led_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [BW-1:0] blink_q, blink_d;
   logic          phase_q, phase_d;
   logic          run_g;

`ifdef GATE_MODE_TIMEOUT_EN
   localparam int            TW        = cnt_w(int'(TIMEOUT_CYCLES));
   localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 28'd1);
   logic [TW-1:0] idle_q, idle_d;
`else
   // Timeout parameter is kept on the interface but has no logic behind it here.
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   // Next-state, mode, counters and LED image; LEDs follow the state being entered.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      hold_d  = hold_q;
      blink_d = blink_q;
      phase_d = phase_q;
`ifdef GATE_MODE_TIMEOUT_EN
      idle_d  = '0;
`endif
      case (state_q)
         ST_RUN: begin
            if (p_lvl[0] & p_lvl[1]) begin
               if (hold_q == HOLD_LAST) begin
                  state_d = ST_ARM;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_q + HW'(1);
               end
            end else begin
               hold_d = '0;
            end
         end
         ST_ARM: begin
            // Wait for a full release so the holding presses are not taken as selections.
            hold_d = '0;
            if (!p_lvl[0] && !p_lvl[1]) begin
               state_d = ST_SELECT;
               blink_d = '0;
               phase_d = 1'b0;
            end
         end
         ST_SELECT: begin
            if (blink_q == BLINK_LAST) begin
               blink_d = '0;
               phase_d = ~phase_q;
            end else begin
               blink_d = blink_q + BW'(1);
            end
            // Exit wins over advance when both buttons land together.
            if (p_press[1]) begin
               state_d = ST_RUN;
            end else if (p_press[0]) begin
               mode_d = mode_q + 2'd1;
            end
`ifdef GATE_MODE_TIMEOUT_EN
            // Any press restarts the idle window, so it also beats a coincident timeout.
            if (p_press[0] | p_press[1]) begin
               idle_d = '0;
            end else if (idle_q == IDLE_LAST) begin
               idle_d  = '0;
               state_d = ST_RUN;
            end else begin
               idle_d = idle_q + TW'(1);
            end
`endif
         end
         default: begin
            state_d = ST_RUN;
            hold_d  = '0;
         end
      endcase

      run_g = gate_eval(mode_d, p_lvl[0], p_lvl[1]);
      case (state_d)
         ST_RUN:    led_d = {~run_g, run_g};
         ST_ARM:    led_d = 2'b11;
         ST_SELECT: led_d = phase_d ? mode_d : 2'b00;
         default:   led_d = 2'b00;
      endcase
   end

   // Mode FSM with registered LED and MODE outputs.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_RUN;
         mode_q  <= MODE_AND;
         led_q   <= 2'b00;
         hold_q  <= '0;
         blink_q <= '0;
         phase_q <= 1'b0;
`ifdef GATE_MODE_TIMEOUT_EN
         idle_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         led_q   <= led_d;
         hold_q  <= hold_d;
         blink_q <= blink_d;
         phase_q <= phase_d;
`ifdef GATE_MODE_TIMEOUT_EN
         idle_q  <= idle_d;
`endif
      end
   end

   assign LED  = led_q;
   assign MODE = mode_q;

endmodule

// File: tb/tb_gate_mode_ctrl.sv
// Directed bench for gate_mode_ctrl with short debounce/hold/blink/timeout periods.
// Latency: n/a.
// Backpressure: n/a.
module tb_gate_mode_ctrl;

   logic       CLK   = 1'b0;
   logic       RST_N = 1'b0;
   logic [1:0] BUT   = 2'b00;
   logic [1:0] LED;
   logic [1:0] MODE;

   int n_checks = 0;
   int n_fail   = 0;

   gate_mode_ctrl #(
      .DEBOUNCE_CYCLES (16'd4),
      .HOLD_CYCLES     (24'd16),
      .BLINK_CYCLES    (24'd8),
      .TIMEOUT_CYCLES  (28'd64)
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .BUT   (BUT),
      .LED   (LED),
      .MODE  (MODE)
   );

   always #5 CLK = ~CLK;

   // LED vectors below are {LED[1], LED[0]}; LED[0] carries the gate, LED[1] its inverse.
   typedef struct {
      logic [1:0] mode;
      logic [1:0] but;
      logic [1:0] led;
   } vec_t;

   vec_t vecs [12];

   task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Advance n rising edges and land on the following falling edge.
   task automatic cyc(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic tap(input int b);
      BUT[b] = 1'b0;
      cyc(8);
      BUT[b] = 1'b1;
      cyc(8);
   endtask

   task automatic run_table(input logic [1:0] mode);
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].mode == mode) begin
            BUT = vecs[i].but;
            cyc(10);
            chk2($sformatf("table%0d_led", i), LED, vecs[i].led);
            chk2($sformatf("table%0d_mode", i), MODE, mode);
         end
      end
   endtask

   // From RUN with both released: hold both into ARM, then release into SELECT.
   task automatic enter_select(input logic [1:0] exp_run_led);
      BUT = 2'b00;
      cyc(21);
      chk2("hold_last_run", LED, exp_run_led);
      cyc(1);
      chk2("hold_arm", LED, 2'b11);
      BUT = 2'b11;
      cyc(7);
      chk2("select_entry", LED, 2'b00);
   endtask

   initial begin
      int         flag;
      int         on_cnt;
      int         other_cnt;
      logic [1:0] wrap_exp [4];

      vecs[0]  = '{2'd0, 2'b10, 2'b10};
      vecs[1]  = '{2'd0, 2'b00, 2'b01};
      vecs[2]  = '{2'd0, 2'b01, 2'b10};
      vecs[3]  = '{2'd0, 2'b11, 2'b10};
      vecs[4]  = '{2'd2, 2'b10, 2'b01};
      vecs[5]  = '{2'd2, 2'b00, 2'b10};
      vecs[6]  = '{2'd2, 2'b01, 2'b01};
      vecs[7]  = '{2'd2, 2'b11, 2'b10};
      vecs[8]  = '{2'd3, 2'b10, 2'b01};
      vecs[9]  = '{2'd3, 2'b00, 2'b10};
      vecs[10] = '{2'd3, 2'b01, 2'b01};
      vecs[11] = '{2'd3, 2'b11, 2'b01};
      wrap_exp[0] = 2'd3;
      wrap_exp[1] = 2'd0;
      wrap_exp[2] = 2'd1;
      wrap_exp[3] = 2'd2;

      // Reset held with both buttons pressed.
      cyc(3);
      chk2("reset_led", LED, 2'b00);
      chk2("reset_mode", MODE, 2'd0);

      BUT   = 2'b11;
      RST_N = 1'b1;
      cyc(1);
      chk2("first_edge_led", LED, 2'b10);
      chk2("first_edge_mode", MODE, 2'd0);

      // A 3-cycle bounce must not reach the debounced level.
      BUT[0] = 1'b0;
      cyc(3);
      BUT[0] = 1'b1;
      flag = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         if (dut.p_lvl[0] !== 1'b0) flag = 1;
      end
      chk_int("glitch_p0", flag, 0);
      chk2("glitch_led", LED, 2'b10);

      // Held press: debounced level rises on edge 6 after the raw change.
      BUT[0] = 1'b0;
      cyc(5);
      chk2("p0_edge5", {1'b0, dut.p_lvl[0]}, 2'b00);
      cyc(1);
      chk2("p0_edge6", {1'b0, dut.p_lvl[0]}, 2'b01);
      cyc(4);
      chk2("and_one_held_led", LED, 2'b10);
      BUT[0] = 1'b1;
      cyc(10);

      run_table(2'd0);

      // Hold into ARM; a press while in ARM must not touch MODE.
      enter_select_arm: begin
         BUT = 2'b00;
         cyc(21);
         chk2("and_hold_last_run", LED, 2'b01);
         cyc(1);
         chk2("and_arm_entry", LED, 2'b11);
         BUT = 2'b01;
         cyc(8);
         BUT = 2'b00;
         cyc(8);
         chk2("arm_press_led", LED, 2'b11);
         chk2("arm_press_mode", MODE, 2'd0);
         BUT = 2'b11;
         cyc(6);
         chk2("arm_wait_release", LED, 2'b11);
         cyc(1);
         chk2("and_select_entry", LED, 2'b00);
      end

      tap(0);
      chk2("sel_tap1_mode", MODE, 2'd1);
      tap(0);
      chk2("sel_tap2_mode", MODE, 2'd2);

      // Steady SELECT over 16 cycles: 8 cycles showing MODE, 8 dark.
      on_cnt    = 0;
      other_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(1);
         if (LED == 2'b10) on_cnt++;
         else if (LED != 2'b00) other_cnt++;
      end
      chk_int("blink_on_cycles", on_cnt, 8);
      chk_int("blink_bad_cycles", other_cnt, 0);

      tap(1);
      chk2("exit_mode", MODE, 2'd2);
      chk2("exit_xor_led", LED, 2'b10);

      run_table(2'd2);

      // Four advances wrap back to the entry mode.
      enter_select(2'b10);
      for (int i = 0; i < 4; i++) begin
         tap(0);
         chk2($sformatf("wrap_tap%0d_mode", i), MODE, wrap_exp[i]);
      end
      tap(0);
      chk2("to_nand_mode", MODE, 2'd3);

      // Both presses in one cycle: exit wins, MODE kept.
      BUT = 2'b00;
      cyc(8);
      chk2("both_press_mode", MODE, 2'd3);
      chk2("both_press_led", LED, 2'b10);
      BUT = 2'b11;
      cyc(10);
      chk2("both_press_released_led", LED, 2'b01);

      run_table(2'd3);

      enter_select(2'b10);
`ifdef GATE_MODE_TIMEOUT_EN
      cyc(63);
      chk2("timeout_before_led", LED, 2'b11);
      cyc(1);
      chk2("timeout_exit_led", LED, 2'b01);
      chk2("timeout_exit_mode", MODE, 2'd3);
`else
      flag = 0;
      for (int i = 0; i < 1000; i++) begin
         cyc(1);
         if (LED != 2'b00 && LED != 2'b11) flag = 1;
      end
      chk_int("no_timeout_left_select", flag, 0);
      chk2("no_timeout_mode", MODE, 2'd3);
`endif

      // Asynchronous reset away from any clock edge.
      #2;
      RST_N = 1'b0;
      #1;
      chk2("midop_reset_led", LED, 2'b00);
      chk2("midop_reset_mode", MODE, 2'd0);
      cyc(2);
      RST_N = 1'b1;
      cyc(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
